// File: rtl/alu_operand_stage.sv
// ALU operand stage: resolves rs1/rs2 through the forwarding channels,
// selects ALU operands A/B from the opcode and holds the result in a single
// valid/ready pipeline register with flush.
module alu_operand_stage #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter int REG_AW  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [6:0]                in_opcode,
    input  logic [REG_AW-1:0]         in_rs1_addr,
    input  logic [REG_AW-1:0]         in_rs2_addr,
    input  logic [XLEN-1:0]           in_rs1_data,
    input  logic [XLEN-1:0]           in_rs2_data,
    input  logic [XLEN-1:0]           in_imm,
    input  logic [XLEN-1:0]           in_pc,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           alu_a,
    output logic [XLEN-1:0]           alu_b,
    output logic [XLEN-1:0]           out_rs2,
    output logic [6:0]                out_opcode,
    output logic [XLEN-1:0]           out_pc,
    output logic                      out_illegal,
    output logic [1:0]                out_fwd_hit
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Returns {hit, value}. Channels are scanned from the oldest down to the
    // youngest so the lowest hitting index is the last to overwrite.
    // x0 is never forwarded.
    function automatic logic [XLEN:0] resolve_src(
        input logic [REG_AW-1:0]         addr,
        input logic [XLEN-1:0]           rf_data,
        input logic [NUM_FWD-1:0]        vld,
        input logic [NUM_FWD*REG_AW-1:0] rd,
        input logic [NUM_FWD*XLEN-1:0]   data
    );
        logic [XLEN:0] res;
        res = {1'b0, rf_data};
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (vld[i] && (rd[i*REG_AW +: REG_AW] == addr) && (addr != {REG_AW{1'b0}})) begin
                res = {1'b1, data[i*XLEN +: XLEN]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    logic [XLEN:0]   rs1_res_s;
    logic [XLEN:0]   rs2_res_s;
    logic [XLEN-1:0] a_s;
    logic [XLEN-1:0] b_s;
    logic            illegal_s;
    logic            use_rs1_s;
    logic            use_rs2_s;
    logic [1:0]      hit_s;
    logic            in_ready_s;
    logic            accept_s;

    logic            valid_r;
    logic [XLEN-1:0] a_r;
    logic [XLEN-1:0] b_r;
    logic [XLEN-1:0] rs2_r;
    logic [6:0]      opcode_r;
    logic [XLEN-1:0] pc_r;
    logic            illegal_r;
    logic [1:0]      hit_r;

    assign rs1_res_s = resolve_src(in_rs1_addr, in_rs1_data, fwd_valid, fwd_rd, fwd_data);
    assign rs2_res_s = resolve_src(in_rs2_addr, in_rs2_data, fwd_valid, fwd_rd, fwd_data);

    // Operand selection per opcode class; also records which sources the
    // instruction really reads so the debug hit flags stay meaningful.
    always_comb begin
        a_s       = {XLEN{1'b0}};
        b_s       = {XLEN{1'b0}};
        illegal_s = 1'b0;
        use_rs1_s = 1'b0;
        use_rs2_s = 1'b0;
        case (in_opcode)
            OP_R: begin
                a_s       = rs1_res_s[XLEN-1:0];
                b_s       = rs2_res_s[XLEN-1:0];
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
            end
            OP_I, OP_LOAD, OP_JALR: begin
                a_s       = rs1_res_s[XLEN-1:0];
                b_s       = in_imm;
                use_rs1_s = 1'b1;
            end
            OP_S: begin
                a_s       = rs1_res_s[XLEN-1:0];
                b_s       = in_imm;
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
            end
            OP_BRANCH: begin
                a_s       = in_pc;
                b_s       = in_imm;
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
            end
            OP_JAL, OP_AUIPC: begin
                a_s = in_pc;
                b_s = in_imm;
            end
            OP_LUI: begin
                // immediate arrives already upper-aligned
                b_s = in_imm;
            end
            default: begin
                // undecoded opcode still flows down the pipe; execute traps it
                illegal_s = 1'b1;
            end
        endcase
    end

    assign hit_s      = {rs2_res_s[XLEN] & use_rs2_s, rs1_res_s[XLEN] & use_rs1_s};
    assign in_ready_s = !valid_r || out_ready;
    assign accept_s   = in_valid && in_ready_s;

    // Pipeline register: reset > flush > accept > transfer > hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r   <= 1'b0;
            a_r       <= {XLEN{1'b0}};
            b_r       <= {XLEN{1'b0}};
            rs2_r     <= {XLEN{1'b0}};
            opcode_r  <= 7'b0000000;
            pc_r      <= {XLEN{1'b0}};
            illegal_r <= 1'b0;
            hit_r     <= 2'b00;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (accept_s) begin
            valid_r   <= 1'b1;
            a_r       <= a_s;
            b_r       <= b_s;
            rs2_r     <= rs2_res_s[XLEN-1:0];
            opcode_r  <= in_opcode;
            pc_r      <= in_pc;
            illegal_r <= illegal_s;
            hit_r     <= hit_s;
        end else if (valid_r && out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = valid_r;
    assign alu_a       = a_r;
    assign alu_b       = b_r;
    assign out_rs2     = rs2_r;
    assign out_opcode  = opcode_r;
    assign out_pc      = pc_r;
    assign out_illegal = illegal_r;
    assign out_fwd_hit = hit_r;

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Registered, parametrised successor to the ALU operand select for the pipelined core.
- Sits between decode and execute:
  - selects ALU A/B per opcode;
  - resolves RS1/RS2 hazards through NUM_FWD forwarding channels;
  - holds the result in one pipeline register with valid/ready handshake and flush.

Parameters:
XLEN, 32, operand/data width
NUM_FWD, 2, forwarding channels; index 0 = youngest producer, highest priority
REG_AW, 5, register address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  decode holds a valid instruction
in_ready  out  1  stage can accept
in_opcode  in  7  RV32I opcode field
in_rs1_addr  in  REG_AW  rs1 index
in_rs2_addr  in  REG_AW  rs2 index
in_rs1_data  in  XLEN  regfile rs1 value
in_rs2_data  in  XLEN  regfile rs2 value
in_imm  in  XLEN  sign-extended/shifted immediate
in_pc  in  XLEN  instruction PC
fwd_valid  in  NUM_FWD  channel carries a register write
fwd_rd  in  NUM_FWD*REG_AW  destination index, channel i at [i*REG_AW +: REG_AW]
fwd_data  in  NUM_FWD*XLEN  write data, channel i at [i*XLEN +: XLEN]
flush  in  1  kill held and incoming instruction
out_valid  out  1  alu_a/alu_b valid
out_ready  in  1  execute accepts
alu_a  out  XLEN  ALU operand A
alu_b  out  XLEN  ALU operand B
out_rs2  out  XLEN  forwarded rs2 (store data / branch compare)
out_opcode  out  7  registered opcode
out_pc  out  XLEN  registered PC
out_illegal  out  1  opcode not decoded
out_fwd_hit  out  2  {rs2 forwarded, rs1 forwarded}, debug

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - rst is synchronous and active-high.
  - On reset, every output register is 0: out_valid, alu_a, alu_b, out_rs2, out_opcode, out_pc, out_illegal, out_fwd_hit.
- Handshake:
  - in_ready = !out_valid || out_ready, combinational and independent of in_valid.
  - Accept = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
  - All out_* fields are stable while out_valid && !out_ready.
- Latency:
  - 1 cycle: operands computed from inputs and forwarding at the accept edge are visible the next cycle.
  - No operand re-evaluation while stalled; producers stall until consumed.
- Register update per edge:
  - Accept: out_valid=1 and all fields load.
  - Otherwise, transfer: out_valid=0 and fields hold.
  - Otherwise: hold.
  - Simultaneous transfer and accept loads the new instruction (full throughput).
- flush:
  - Next cycle out_valid=0 and any same-cycle accept is discarded.
  - flush has priority over accept.
  - rst has priority over flush.
- Forwarding, per source s in {rs1, rs2}:
  - Channel i hits if fwd_valid[i] && fwd_rd[i]==s_addr && s_addr!=0.
  - Lowest hitting index wins; no hit uses in_sX_data.
  - Address 0 always yields in_sX_data, never forwarded.
- Operand select on resolved values r1 and r2:
  - R (0110011): A=r1, B=r2
  - I (0010011), LOAD (0000011), JALR (1100111), S (0100011): A=r1, B=imm
  - JAL (1101111), BRANCH (1100011): A=pc, B=imm
  - LUI (0110111): A=0, B=imm. The immediate is already upper-aligned; no shift operand.
  - AUIPC (0010111): A=pc, B=imm
  - Any other: A=0, B=0, out_illegal=1. The instruction still flows; execute traps.
- out_rs2 = r2 for every opcode.
- out_fwd_hit reflects hits only for sources that the selected opcode actually uses:
  - rs2 hit is reported only for R, S and BRANCH.
  - JAL, LUI and AUIPC report 0.
- Arithmetic: pure selection, no arithmetic and no width change; all values are XLEN.

Test Plan:
1. Reset and basic flow: rst=1 for 2 cycles → all outputs 0 and in_ready=1. Then issue R-type with rs1_data=0x10, rs2_data=0x20 → next cycle out_valid=1, alu_a=0x10, alu_b=0x20, out_fwd_hit=00.
2. Forward priority: rs1=x5, fwd_valid=11, fwd_rd[0]=5 with data 0xAAAA, fwd_rd[1]=5 with data 0xBBBB → alu_a=0xAAAA, out_fwd_hit[0]=1. Repeat with rs1=x0 and both channels targeting 0 → alu_a=in_rs1_data.
3. Opcode sweep at pc=0x100, imm=0x12345000, r1=0x7:
   - LUI → A=0, B=0x12345000.
   - AUIPC and JAL → A=0x100, B=0x12345000.
   - LOAD → A=0x7, B=imm.
   - opcode 0x7F → A=B=0 and out_illegal=1.
4. Backpressure: out_ready=0 for 3 cycles with in_valid held → in_ready=0, outputs stable, no accept. Raise out_ready with a new in_valid in the same cycle → back-to-back transfer, next instruction appears the following cycle.
5. Flush: accept in the same cycle flush=1 → next cycle out_valid=0. Flush while stalled with out_valid=1 → out_valid=0 next cycle, in_ready=1.
6. Store data path: S-type with rs2 forwarded from channel 1 (0xDEAD) → alu_b=imm, out_rs2=0xDEAD, out_fwd_hit=10.
